fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. Owns the PC, issues reads to the stall-capable instruction memory, and presents instruction, current PC and PC+2 to the IF/ID pipeline register each cycle. Absorbs downstream stalls with a one-entry hold buffer, accepts branch/jump redirects from later stages, and stops fetching after a HALT.

## Interface
- RESET_PC, 16'h0000, PC value after reset
- NOP_INSTR, 16'h0800, instruction emitted when no valid instruction (opcode 00001)
- HALT_OPC, 5'b00000, opcode that stops fetch
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  downstream hazard stall; IF/ID not loading this cycle
- redirect  in  1  taken branch/jump/exception redirect
- redirect_pc  in  16  redirect target; bit 0 forced to 0
- imem_addr  out  16  instruction memory address
- imem_rd  out  1  read request
- imem_data  in  16  read data, valid when imem_done
- imem_stall  in  1  memory busy (miss in progress)
- imem_done  in  1  read complete this cycle (may be same cycle as imem_rd)
- instr_out  out  16  fetched instruction, NOP_INSTR when instr_valid=0
- pcCurrent_out  out  16  address of instr_out
- pcPlusTwo_out  out  16  pcCurrent_out + 2
- instr_valid  out  1  instr_out is a real instruction
- halted  out  1  fetch stopped on HALT

## Operation
- States: RUN, WAIT, HOLD, HALT. Registers: pc, hold_instr, hold_pc, squash.
- RUN: imem_rd=1, imem_addr=pc.
  - imem_done & !stall: emit imem_data, valid=1, pc<=pc+2; opcode==HALT_OPC -> HALT.
  - imem_done & stall: capture into hold_instr/hold_pc, pc<=pc+2, -> HOLD (or HALT-after-HOLD: HALT entered when HOLD drains).
  - !imem_done: -> WAIT, address latched.
- WAIT: imem_rd=0, imem_addr held; on imem_done behave as RUN's done cases.
- HOLD: no read; emit hold buffer, valid=1; when !stall -> RUN (or HALT if held instr is HALT).
- HALT: no read, halted=1, outputs NOP/valid=0.
- redirect (highest priority, any state): pc<=redirect_pc, hold buffer discarded, output valid=0 that cycle. From WAIT: squash<=1, stay WAIT until imem_done, discard data, -> RUN. From HALT/HOLD/RUN: -> RUN next cycle (RUN read in redirect cycle is dropped: imem_rd=0 that cycle).
- Invalid outputs: instr_out=NOP_INSTR; pcCurrent_out/pcPlusTwo_out hold last values.
- PC arithmetic modulo 2^16: 16'hFFFE + 2 = 16'h0000.

## Timing
- Outputs combinational from imem_data (done cycle) or hold buffer; regIFID registers them.
- Hit latency: instruction valid in same cycle as request; one instruction per cycle with no stalls/misses.
- Miss: valid in the imem_done cycle; no new request until then.
- Reset (rst=0 at edge): pc=RESET_PC, state RUN, squash=0; during reset imem_rd=0, instr_valid=0, instr_out=NOP_INSTR, halted=0, pcCurrent_out=RESET_PC, pcPlusTwo_out=RESET_PC+2. Reset mid-miss abandons the access; memory assumed reset in same cycle.
- stall and redirect together: redirect wins.

## Structure
- Shared package: state encoding, NOP_INSTR, HALT_OPC, RESET_PC.
- pc, hold_instr, hold_pc use existing dff_16bit; no other sub-module.

## Test plan
- Reset then 4 hits, mem[0..6]=1111,2222,3333,4444 -> valid each cycle, pcCurrent 0,2,4,6, pcPlusTwo 2,4,6,8.
- Miss at 0x0004, imem_done 3 cycles later -> imem_addr held 0x0004, valid=0 for 3 cycles, then instr with pcCurrent=0x0004.
- stall for 2 cycles while done at 0x0002 -> hold buffer presents instr/0x0002 for 2 cycles, no imem_rd, resumes at 0x0004.
- redirect to 0x0101 during WAIT -> pending data discarded, next request at 0x0100.
- HALT at 0x000A -> halted=1, no further imem_rd; redirect to 0x0020 resumes fetch.
- PC 0xFFFE fetch -> pcPlusTwo_out=0x0000, next request 0x0000; rst=0 mid-miss -> PC 0x0000, valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: fetch state encoding, reset/NOP/HALT constants and the HALT opcode test
package fetch_stage_pkg;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HOLD, S_HALT} state_t;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0] HALT_OPC = 5'b00000;
  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPC;
  endfunction
endpackage

// File: rtl/dff_16bit.sv
// dff_16bit: 16-bit register with synchronous active-low reset to RST_VAL (clk, rst, d -> q)
module dff_16bit #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    q <= !rst ? RST_VAL : d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing imem reads, one-entry hold buffer for stalls, redirects, HALT stop; outputs instr/pc/pc+2/valid/halted to IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  output logic [15:0] instr_out,
  output logic [15:0] pcCurrent_out,
  output logic [15:0] pcPlusTwo_out,
  output logic        instr_valid,
  output logic        halted
);
  state_t state, state_n;
  logic squash, squash_n, valid, unused_ok;
  logic [15:0] pc_q, pc_d, hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
  logic [15:0] emit_instr, emit_pc, last_pc;
  assign unused_ok = ^{imem_stall, redirect_pc[0]};
  dff_16bit #(.RST_VAL(RESET_PC)) u_pc (.clk(clk), .rst(rst), .d(pc_d), .q(pc_q));
  dff_16bit #(.RST_VAL(NOP_INSTR)) u_hold_instr (.clk(clk), .rst(rst), .d(hold_instr_d), .q(hold_instr_q));
  dff_16bit #(.RST_VAL(RESET_PC)) u_hold_pc (.clk(clk), .rst(rst), .d(hold_pc_d), .q(hold_pc_q));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_RUN;
      squash <= 1'b0;
      last_pc <= RESET_PC;
    end else begin
      state <= state_n;
      squash <= squash_n;
      last_pc <= pcCurrent_out;
    end
  end
  // hold_pc doubles as the latched miss address while in S_WAIT
  always_comb begin
    state_n = state;
    squash_n = squash;
    pc_d = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d = hold_pc_q;
    imem_rd = 1'b0;
    imem_addr = pc_q;
    valid = 1'b0;
    emit_instr = imem_data;
    emit_pc = pc_q;
    case (state)
      S_RUN: begin
        imem_rd = 1'b1;
        hold_pc_d = pc_q;
        hold_instr_d = imem_data;
        valid = imem_done;
        pc_d = imem_done ? pc_q + 16'd2 : pc_q;
        state_n = !imem_done ? S_WAIT : stall ? S_HOLD : is_halt(imem_data) ? S_HALT : S_RUN;
      end
      S_WAIT: begin
        imem_addr = hold_pc_q;
        emit_pc = hold_pc_q;
        hold_instr_d = imem_data;
        valid = imem_done && !squash;
        pc_d = valid ? pc_q + 16'd2 : pc_q;
        squash_n = squash && !imem_done;
        state_n = !imem_done ? S_WAIT : squash ? S_RUN : stall ? S_HOLD : is_halt(imem_data) ? S_HALT : S_RUN;
      end
      S_HOLD: begin
        valid = 1'b1;
        emit_instr = hold_instr_q;
        emit_pc = hold_pc_q;
        state_n = stall ? S_HOLD : is_halt(hold_instr_q) ? S_HALT : S_RUN;
      end
      default: ;
    endcase
    // a redirect during an outstanding miss must wait for the old data before reissuing
    if (redirect) begin
      imem_rd = 1'b0;
      valid = 1'b0;
      pc_d = {redirect_pc[15:1], 1'b0};
      squash_n = state == S_WAIT && !imem_done;
      state_n = squash_n ? S_WAIT : S_RUN;
    end
    if (!rst) begin
      imem_rd = 1'b0;
      valid = 1'b0;
    end
  end
  assign instr_valid = valid;
  assign instr_out = valid ? emit_instr : NOP_INSTR;
  assign pcCurrent_out = !rst ? RESET_PC : valid ? emit_pc : last_pc;
  assign pcPlusTwo_out = pcCurrent_out + 16'd2;
  assign halted = rst && state == S_HALT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst, stall, redirect, imem_stall, imem_done, imem_rd, instr_valid, halted;
  logic [15:0] redirect_pc, imem_data, imem_addr, instr_out, pcCurrent_out, pcPlusTwo_out;
  logic [95:0] obs, want;
  int errors = 0;
  int checks = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data), .imem_stall(imem_stall),
    .imem_done(imem_done), .instr_out(instr_out), .pcCurrent_out(pcCurrent_out),
    .pcPlusTwo_out(pcPlusTwo_out), .instr_valid(instr_valid), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic r, s, rd, input logic [15:0] rp, input logic dn, input logic [15:0] d);
    rst = r;
    stall = s;
    redirect = rd;
    redirect_pc = rp;
    imem_done = dn;
    imem_stall = ~dn;
    imem_data = d;
    #2;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
      obs = {imem_rd, instr_valid, halted, instr_out, pcCurrent_out, pcPlusTwo_out};
      want = {1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0002};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL reset%0d got %h exp %h", i, obs, want); end
      tick();
    end
  endtask
  task automatic test_hits;
    logic [15:0] tab [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, tab[i]);
      obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out, pcPlusTwo_out};
      want = {1'b1, 16'(2 * i), 1'b1, tab[i], 16'(2 * i), 16'(2 * i + 2)};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL hit%0d got %h exp %h", i, obs, want); end
      tick();
    end
  endtask
  task automatic test_miss;
    drive(1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0);
    obs = {imem_rd, instr_valid, instr_out};
    want = {1'b0, 1'b0, 16'h0800};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL miss_redir got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b1, 16'h0004, 1'b0, 16'h0800, 16'h0006};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL miss_req got %h exp %h", obs, want); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      obs = {imem_rd, imem_addr, instr_valid, pcCurrent_out};
      want = {1'b0, 16'h0004, 1'b0, 16'h0006};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL miss_wait%0d got %h exp %h", i, obs, want); end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out, pcPlusTwo_out};
    want = {1'b0, 16'h0004, 1'b1, 16'h5555, 16'h0004, 16'h0006};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL miss_done got %h exp %h", obs, want); end
    tick();
  endtask
  task automatic test_stall;
    drive(1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h6666);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b1, 16'h0002, 1'b1, 16'h6666, 16'h0002};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL stall_cap got %h exp %h", obs, want); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, k == 0, 1'b0, 16'h0, 1'b0, 16'h0);
      obs = {imem_rd, instr_valid, instr_out, pcCurrent_out};
      want = {1'b0, 1'b1, 16'h6666, 16'h0002};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", k, obs, want); end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h7777);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b1, 16'h0004, 1'b1, 16'h7777, 16'h0004};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL stall_resume got %h exp %h", obs, want); end
    tick();
  endtask
  task automatic test_redirect_wait;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    obs = {imem_rd, imem_addr, instr_valid};
    want = {1'b1, 16'h0006, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rw_req got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0);
    obs = {imem_rd, imem_addr, instr_valid, instr_out};
    want = {1'b0, 16'h0006, 1'b0, 16'h0800};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rw_redir got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h8888);
    obs = {imem_rd, imem_addr, instr_valid, instr_out};
    want = {1'b0, 16'h0006, 1'b0, 16'h0800};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rw_squash got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h9999);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b1, 16'h0100, 1'b1, 16'h9999, 16'h0100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rw_new got %h exp %h", obs, want); end
    tick();
  endtask
  task automatic test_halt;
    drive(1'b1, 1'b0, 1'b1, 16'h000A, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out, halted};
    want = {1'b1, 16'h000A, 1'b1, 16'h0000, 16'h000A, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL halt_fetch got %h exp %h", obs, want); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      obs = {halted, imem_rd, instr_valid, instr_out, pcCurrent_out};
      want = {1'b1, 1'b0, 1'b0, 16'h0800, 16'h000A};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL halted%0d got %h exp %h", i, obs, want); end
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0);
    obs = {imem_rd, instr_valid};
    want = {1'b0, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL halt_redir got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'hA5A5);
    obs = {halted, imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b0, 1'b1, 16'h0020, 1'b1, 16'hA5A5, 16'h0020};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL halt_resume got %h exp %h", obs, want); end
    tick();
  endtask
  task automatic test_stall_redirect;
    drive(1'b1, 1'b0, 1'b1, 16'h0030, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h1357);
    obs = {imem_rd, imem_addr, instr_valid, instr_out};
    want = {1'b1, 16'h0030, 1'b1, 16'h1357};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sr_cap got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0);
    obs = {imem_rd, instr_valid, instr_out};
    want = {1'b0, 1'b0, 16'h0800};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sr_both got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2468);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b1, 16'h0040, 1'b1, 16'h2468, 16'h0040};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sr_resume got %h exp %h", obs, want); end
    tick();
  endtask
  task automatic test_wrap_reset;
    drive(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
    obs = {imem_rd, imem_addr, instr_valid, pcCurrent_out, pcPlusTwo_out};
    want = {1'b1, 16'hFFFE, 1'b1, 16'hFFFE, 16'h0000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL wrap_top got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h4321);
    obs = {imem_rd, imem_addr, instr_valid, pcCurrent_out, pcPlusTwo_out};
    want = {1'b1, 16'h0000, 1'b1, 16'h0000, 16'h0002};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL wrap_zero got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    obs = {imem_rd, imem_addr};
    want = {1'b1, 16'h0002};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rstmiss_req got %h exp %h", obs, want); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    obs = {imem_rd, instr_valid, instr_out, pcCurrent_out, pcPlusTwo_out, halted};
    want = {1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rstmiss_rst got %h exp %h", obs, want); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h6789);
    obs = {imem_rd, imem_addr, instr_valid, instr_out, pcCurrent_out};
    want = {1'b1, 16'h0000, 1'b1, 16'h6789, 16'h0000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rstmiss_after got %h exp %h", obs, want); end
    tick();
  endtask
  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_stall_redirect();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
